pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipelined RISC-V core.
- Decides each cycle whether PC and IF/ID advance, hold, or flush.
- Decides whether ID/EX receives a bubble.
- Detects the halting ecall (x17==10) in ID, drains the older in-flight instructions, then asserts a sticky is_halted.
- Keeps saturating stall/flush statistics for the bench.

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC / IF/ID / ID/EX sequencing for the 5-stage core.
// Resolves redirect flushes, RAW hazard stalls and the halting ecall
// (x17==10), which drains the older instructions before a sticky halt.
// Build option: define FWD_EN when the forwarding datapath is present;
// only load-use then stalls. Undefined, any EX/MEM/WB RAW match stalls.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_ecall,
    input  logic             id_x17_eq10,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halt_pending,
    output logic             is_halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic [CNT_W-1:0]    flush_count_q, flush_count_d;
    logic                halt_pending_q, halt_pending_d;
    logic                is_halted_q, is_halted_d;
    logic                ex_match, mem_match, wb_match, hazard;
    logic                stall_inc, flush_inc;

    // Producer in stage S writes a non-x0 register that ID reads.
    function automatic logic src_match(input logic       rw,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic       use1,
                                       input logic       use2);
        return rw && (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    // Per-stage source matches and the build-dependent hazard condition.
    always_comb begin
        ex_match  = src_match(ex_reg_write,  ex_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);
        mem_match = src_match(mem_reg_write, mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
        wb_match  = src_match(wb_reg_write,  wb_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);
`ifdef FWD_EN
        hazard    = ex_match && ex_mem_read;
`else
        hazard    = ex_match || mem_match || wb_match;
`endif
    end

`ifdef FWD_EN
    // MEM/WB matches are resolved by forwarding in this build.
    logic unused_fwd;
    assign unused_fwd = mem_match ^ wb_match;
`endif

    // Control outputs and next state from current state and ID/EX/MEM/WB view.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    // Squashes everything in IF/ID, including a halting ecall.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_inc    = 1'b1;
                end else if (hazard) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_inc    = 1'b1;
                end else if (id_is_ecall && id_x17_eq10) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_DRAIN;
                    drain_cnt_d  = DCNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCNT_W'(1);
                end
            end
            ST_HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_count_d  = (stall_inc && !(&stall_count_q)) ? stall_count_q + CNT_W'(1)
                                                          : stall_count_q;
        flush_count_d  = (flush_inc && !(&flush_count_q)) ? flush_count_q + CNT_W'(1)
                                                          : flush_count_q;
        halt_pending_d = (state_d == ST_DRAIN);
        is_halted_d    = (state_d == ST_HALTED);
    end

    // State, drain counter, status flags and saturating statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            drain_cnt_q    <= '0;
            stall_count_q  <= '0;
            flush_count_q  <= '0;
            halt_pending_q <= 1'b0;
            is_halted_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_count_q  <= stall_count_d;
            flush_count_q  <= flush_count_d;
            halt_pending_q <= halt_pending_d;
            is_halted_q    <= is_halted_d;
        end
    end

    assign halt_pending = halt_pending_q;
    assign is_halted    = is_halted_q;
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (honours FWD_EN).
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW  = 4;
    localparam int unsigned SAT = (1 << CW) - 1;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, id_is_ecall, id_x17_eq10;
    logic          ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_redirect;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic          halt_pending, is_halted;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_ecall(id_is_ecall), .id_x17_eq10(id_x17_eq10),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_redirect(ex_redirect),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .halt_pending(halt_pending), .is_halted(is_halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2, ec, x17;
        logic [4:0] exrd;
        logic       exrw, exmr;
        logic [4:0] memrd;
        logic       memrw;
        logic [4:0] wbrd;
        logic       wbrw, redir;
        logic       pw, iw, fl, bb, si, fi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic ec, logic x17, logic [4:0] exrd, logic exrw, logic exmr,
                                logic [4:0] memrd, logic memrw, logic [4:0] wbrd, logic wbrw,
                                logic redir, logic pw, logic iw, logic fl, logic bb,
                                logic si, logic fi);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ec = ec; v.x17 = x17;
        v.exrd = exrd; v.exrw = exrw; v.exmr = exmr; v.memrd = memrd; v.memrw = memrw;
        v.wbrd = wbrd; v.wbrw = wbrw; v.redir = redir;
        v.pw = pw; v.iw = iw; v.fl = fl; v.bb = bb; v.si = si; v.fi = fi;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        id_is_ecall = v.ec; id_x17_eq10 = v.x17;
        ex_rd = v.exrd; ex_reg_write = v.exrw; ex_mem_read = v.exmr;
        mem_rd = v.memrd; mem_reg_write = v.memrw; wb_rd = v.wbrd; wb_reg_write = v.wbrw;
        ex_redirect = v.redir;
    endtask

    function automatic int sat_inc(int x);
        return (x >= int'(SAT)) ? int'(SAT) : x + 1;
    endfunction

    vec_t idle, ecall_v, hz_v, rd_v;

    initial begin
        idle    = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        ecall_v = mk("halt_ecall", 17, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        hz_v    = mk("load_use", 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        rd_v    = mk("redirect", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1);

        vecs.push_back(idle);
        vecs.push_back(hz_v);
        vecs.push_back(mk("ex_alu_raw", 5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,
                          FWD, FWD, 0, !FWD, !FWD, 0));
        vecs.push_back(mk("mem_raw_rs2", 0, 3, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0,
                          FWD, FWD, 0, !FWD, !FWD, 0));
        vecs.push_back(mk("mem_rd0", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ex_load_rd0", 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("wb_raw_rs1", 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0,
                          FWD, FWD, 0, !FWD, !FWD, 0));
        vecs.push_back(mk("no_use", 5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("no_regwr", 5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("redir_over_all", 17, 0, 1, 0, 1, 1, 17, 1, 1, 0, 0, 0, 0, 1,
                          1, 1, 1, 1, 0, 1));
        vecs.push_back(mk("ecall_not10", 17, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("hazard_over_ecall", 17, 0, 1, 0, 1, 1, 17, 1, 1, 0, 0, 0, 0, 0,
                          0, 0, 0, 1, 1, 0));
        vecs.push_back(idle);
        vecs.push_back(mk("load_use_rs2", 0, 9, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(idle);

        // Reset state.
        drive(idle);
        reset = 1'b0;
        #12;
        chk("rst_pc_write", int'(pc_write), 1);
        chk("rst_if_id_write", int'(if_id_write), 1);
        chk("rst_if_id_flush", int'(if_id_flush), 0);
        chk("rst_bubble", int'(id_ex_bubble), 0);
        chk("rst_halt_pending", int'(halt_pending), 0);
        chk("rst_is_halted", int'(is_halted), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        chk("rst_flush_count", int'(flush_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // Table of single-cycle vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk({vecs[i].name, "_pc_write"}, int'(pc_write), int'(vecs[i].pw));
            chk({vecs[i].name, "_if_id_write"}, int'(if_id_write), int'(vecs[i].iw));
            chk({vecs[i].name, "_if_id_flush"}, int'(if_id_flush), int'(vecs[i].fl));
            chk({vecs[i].name, "_bubble"}, int'(id_ex_bubble), int'(vecs[i].bb));
            if (vecs[i].si) exp_stall = sat_inc(exp_stall);
            if (vecs[i].fi) exp_flush = sat_inc(exp_flush);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_stall_count"}, int'(stall_count), exp_stall);
            chk({vecs[i].name, "_flush_count"}, int'(flush_count), exp_flush);
            chk({vecs[i].name, "_halt_pending"}, int'(halt_pending), 0);
        end

        // Saturation of both statistics.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(hz_v);
            exp_stall = sat_inc(exp_stall);
            @(negedge clk);
            drive(rd_v);
            exp_flush = sat_inc(exp_flush);
        end
        @(negedge clk);
        drive(idle);
        #1;
        chk("sat_stall_count", int'(stall_count), exp_stall);
        chk("sat_flush_count", int'(flush_count), exp_flush);
        chk("sat_stall_max", int'(stall_count), int'(SAT));

        // Mid-run asynchronous reset clears the statistics.
        #2 reset = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("midrst_stall_count", int'(stall_count), 0);
        chk("midrst_flush_count", int'(flush_count), 0);
        chk("midrst_pc_write", int'(pc_write), 1);
        chk("midrst_if_id_write", int'(if_id_write), 1);
        @(negedge clk);
        reset = 1'b1;

        // Halting ecall at cycle t: DRAIN t+1..t+3, halted from t+4.
        @(negedge clk);
        drive(ecall_v);
        #1;
        chk("halt_t_pc_write", int'(pc_write), 0);
        chk("halt_t_if_id_write", int'(if_id_write), 0);
        chk("halt_t_bubble", int'(id_ex_bubble), 1);
        chk("halt_t_pending", int'(halt_pending), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(rd_v);
            #1;
            chk("drain_pending", int'(halt_pending), 1);
            chk("drain_is_halted", int'(is_halted), 0);
            chk("drain_pc_write", int'(pc_write), 0);
            chk("drain_if_id_write", int'(if_id_write), 0);
            chk("drain_bubble", int'(id_ex_bubble), 1);
            chk("drain_flush", int'(if_id_flush), 0);
        end
        for (int k = 4; k <= 24; k++) begin
            @(negedge clk);
            drive((k % 2 == 0) ? hz_v : rd_v);
            #1;
            chk("halted_is_halted", int'(is_halted), 1);
            chk("halted_pending", int'(halt_pending), 0);
            chk("halted_pc_write", int'(pc_write), 0);
            chk("halted_if_id_write", int'(if_id_write), 0);
            chk("halted_bubble", int'(id_ex_bubble), 1);
        end
        chk("halted_stall_count", int'(stall_count), 0);
        chk("halted_flush_count", int'(flush_count), 0);

        // Reset out of HALTED.
        drive(idle);
        #2 reset = 1'b0;
        #1;
        chk("halt_rst_is_halted", int'(is_halted), 0);
        chk("halt_rst_pc_write", int'(pc_write), 1);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted during DRAIN (cycle t+2).
        @(negedge clk);
        drive(ecall_v);
        @(negedge clk);
        drive(idle);
        #1;
        chk("rdrain_t1_pending", int'(halt_pending), 1);
        @(negedge clk);
        #1;
        chk("rdrain_t2_pending", int'(halt_pending), 1);
        reset = 1'b0;
        #1;
        chk("rdrain_rst_pending", int'(halt_pending), 0);
        chk("rdrain_rst_is_halted", int'(is_halted), 0);
        chk("rdrain_rst_pc_write", int'(pc_write), 1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("resume_pc_write", int'(pc_write), 1);
            chk("resume_pending", int'(halt_pending), 0);
            chk("resume_is_halted", int'(is_halted), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
